// File: rtl/mem_access_ctrl.sv
// Sequencer and fetch/data arbiter for the shared 256x16 memory.
// Ports: clk, rst_n; if_* fetch port; d_* data port; mem_* memory side; busy.
module mem_access_ctrl #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int WR_PULSE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    READ,
    DONE
  } state_t;

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;
  localparam logic [3:0] PULSE_M1 = 4'(WR_PULSE - 1);

  state_t        state, state_nxt;
  logic          gnt, gnt_nxt;
  logic          last, last_nxt;
  logic          we_q, we_nxt;
  logic          err, err_nxt;
  logic          pick;
  logic [3:0]    cnt, cnt_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] wdata_nxt;
  logic [DW-1:0] if_rdata_nxt;
  logic [DW-1:0] d_rdata_nxt;

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_nxt     = last;
    we_nxt       = we_q;
    err_nxt      = err;
    cnt_nxt      = cnt;
    addr_nxt     = mem_addr;
    wdata_nxt    = mem_wdata;
    if_rdata_nxt = if_rdata;
    d_rdata_nxt  = d_rdata;
    pick         = DATA;
    unique case (state)
      IDLE: begin
        if (if_req || d_req) begin
          // Fetch wins alone, or on a tie when data went last.
          pick = (if_req && (!d_req || last == DATA))
                 ? FETCH : DATA;
          gnt_nxt   = pick;
          last_nxt  = pick;
          state_nxt = SETUP;
          if (pick == FETCH) begin
            addr_nxt = if_addr;
            we_nxt   = 1'b0;
          end else begin
            addr_nxt  = d_addr;
            we_nxt    = d_we;
            wdata_nxt = d_wdata;
          end
        end
      end
      SETUP: begin
        if (we_q) begin
          if (mem_addr[AW-1 -: 2] == 2'b00) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            cnt_nxt   = PULSE_M1;
            state_nxt = WRITE;
          end
        end else begin
          state_nxt = READ;
        end
      end
      WRITE: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else cnt_nxt = cnt - 4'd1;
      end
      READ: begin
        if (gnt == FETCH) if_rdata_nxt = mem_rdata;
        else d_rdata_nxt = mem_rdata;
        state_nxt = DONE;
      end
      DONE: begin
        err_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= FETCH;
      last      <= DATA;
      we_q      <= 1'b0;
      err       <= 1'b0;
      cnt       <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      last      <= last_nxt;
      we_q      <= we_nxt;
      err       <= err_nxt;
      cnt       <= cnt_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      // Outputs follow the next state so they stay pure flop outputs.
      mem_wr    <= (state_nxt == WRITE);
      if_ack    <= (state_nxt == DONE) && (gnt_nxt == FETCH);
      d_ack     <= (state_nxt == DONE) && (gnt_nxt == DATA);
      d_err     <= (state_nxt == DONE) && (gnt_nxt == DATA)
                   && err_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule
